// File: rtl/adc_serial_reader_if.sv
// Signal bundle between the ADC serial reader and its environment: ADC pins,
// the conversion request, and the captured result with its status flags.
interface adc_serial_reader_if #(
  parameter int unsigned N_BITS = 8
);
  logic              Sample_req;
  logic              ADC_SDATA;
  logic              ADC_CS_n;
  logic              ADC_SCLK;
  logic [N_BITS-1:0] Dato;
  logic              Dato_valido;
  logic              Ocupado;
  logic              Error_trama;
  logic              Overrun;

  modport slave (
    input  Sample_req, ADC_SDATA,
    output ADC_CS_n, ADC_SCLK, Dato, Dato_valido, Ocupado, Error_trama, Overrun
  );

  modport master (
    output Sample_req, ADC_SDATA,
    input  ADC_CS_n, ADC_SCLK, Dato, Dato_valido, Ocupado, Error_trama, Overrun
  );
endinterface

// File: rtl/adc_serial_reader.sv
// Reads one ADC081S021-style SPI mode 3 frame per rising edge of Sample_req and
// presents the captured sample with a one-cycle valid strobe.
module adc_serial_reader #(
  parameter int unsigned DIV        = 4,
  parameter int unsigned N_BITS     = 8,
  parameter int unsigned LEAD_ZEROS = 3,
  parameter int unsigned FRAME_CLKS = 16
) (
  input logic               Clck_in,
  input logic               reset_Clock,
  adc_serial_reader_if.slave bus_io
);
  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned BitW = $clog2(FRAME_CLKS + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StDone, StQuiet} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [N_BITS-1:0]   shift_q, shift_d;
  logic                pend_err_q, pend_err_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic [N_BITS-1:0]   dato_q, dato_d;
  logic                err_q, err_d;
  logic                ovr_q, ovr_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic                req_edge;
  logic                cnt_last;

  always_ff @(posedge Clck_in or negedge reset_Clock) begin
    if (!reset_Clock) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      pend_err_q <= 1'b0;
      sclk_q     <= 1'b1;
      cs_n_q     <= 1'b1;
      dato_q     <= '0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      pend_err_q <= pend_err_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      dato_q     <= dato_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      sync1_q    <= bus_io.Sample_req;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
    end
  end

  assign req_edge = sync2_q & ~sync3_q;
  assign cnt_last = (cnt_q == CntW'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pend_err_d = pend_err_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    dato_d     = dato_q;
    err_d      = err_q;
    // DONE still counts as busy, so an edge landing there is an overrun.
    ovr_d      = ovr_q | (req_edge & (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (req_edge) begin
          state_d    = StSetup;
          cnt_d      = '0;
          bit_d      = '0;
          shift_d    = '0;
          pend_err_d = 1'b0;
          cs_n_d     = 1'b0;
        end
      end
      StSetup: begin
        if (cnt_last) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (!cnt_last) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Data was launched on the falling edge; capture as SCLK rises.
            sclk_d = 1'b1;
            bit_d  = bit_q + 1'b1;
            if (bit_q < BitW'(LEAD_ZEROS)) begin
              pend_err_d = pend_err_q | bus_io.ADC_SDATA;
            end else if (bit_q < BitW'(LEAD_ZEROS + N_BITS)) begin
              shift_d = {shift_q[N_BITS-2:0], bus_io.ADC_SDATA};
            end
          end else if (bit_q == BitW'(FRAME_CLKS)) begin
            state_d = StDone;
            cs_n_d  = 1'b1;
            dato_d  = shift_q;
            err_d   = pend_err_q;
          end else begin
            sclk_d = 1'b0;
          end
        end
      end
      StDone: begin
        state_d = StQuiet;
        cnt_d   = '0;
      end
      StQuiet: begin
        // DONE plus QUIET together span DIV cycles of quiet time.
        if (cnt_q == CntW'(DIV - 2)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_io.ADC_CS_n    = cs_n_q;
  assign bus_io.ADC_SCLK    = sclk_q;
  assign bus_io.Dato        = dato_q;
  assign bus_io.Dato_valido = (state_q == StDone);
  assign bus_io.Ocupado     = (state_q != StIdle);
  assign bus_io.Error_trama = err_q;
  assign bus_io.Overrun     = ovr_q;
endmodule
